// File: rtl/axil_reg_slave.sv
// AXI4-Lite register-bank responder: CTRL, DATA (RW), STATUS, RESULT (RO) at BASE_ADDR.
// Optional AXIL_STATUS_RDCLR_EN: an OKAY read of STATUS clears it.
module axil_reg_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RESP_WIDTH = 3,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e                 wstate_q, wstate_d;
    rstate_e                 rstate_q, rstate_d;
    logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awready_q, awready_d, wready_q, wready_d;
    logic                    bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
    logic [RESP_WIDTH-1:0]   bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   ctrl_q, ctrl_d, data_q, data_d, status_q, status_d, result_q, result_d;

    logic                    commit_c, commit_ok_c, status_clr_c;
    logic [ADDR_WIDTH-1:0]   eff_addr;
    logic [DATA_WIDTH-1:0]   eff_data;
    logic [STRB_W-1:0]       eff_strb;
    logic                    wstrb_unused;

    // Top strobe bit only pads the bus port width.
    assign wstrb_unused = s_axi_wstrb[STRB_W];

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
        return (32'(addr - ADDR_WIDTH'(BASE_ADDR)) < 32'd16) && (addr[1:0] == 2'b00);
    endfunction

    function automatic logic [1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
        return 2'((addr - ADDR_WIDTH'(BASE_ADDR)) >> 2);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_v,
                                                   input logic [DATA_WIDTH-1:0] new_v,
                                                   input logic [STRB_W-1:0]     strb);
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return res;
    endfunction

    // Write FSM: latch AW and W independently, commit when both are held.
    always_comb begin
        wstate_d    = wstate_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        commit_c    = 1'b0;
        commit_ok_c = 1'b0;
        eff_addr    = aw_held_q ? awaddr_q : s_axi_awaddr;
        eff_data    = w_held_q ? wdata_q : s_axi_wdata;
        eff_strb    = w_held_q ? wstrb_q : s_axi_wstrb[STRB_W-1:0];
        case (wstate_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axi_awaddr;
                end
                if (s_axi_wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb[STRB_W-1:0];
                end
                if (aw_held_d && w_held_d) begin
                    commit_c    = 1'b1;
                    commit_ok_c = addr_ok(eff_addr) && (addr_idx(eff_addr) < 2'd2);
                    bvalid_d    = 1'b1;
                    bresp_d     = commit_ok_c ? RESP_OKAY : RESP_SLVERR;
                    wstate_d    = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

    // Read FSM: register the response on the AR handshake, hold until rready.
    always_comb begin
        rstate_d     = rstate_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        status_clr_c = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    rvalid_d = 1'b1;
                    rstate_d = R_DATA;
                    if (addr_ok(s_axi_araddr)) begin
                        rresp_d = RESP_OKAY;
                        case (addr_idx(s_axi_araddr))
                            2'd0:    rdata_d = ctrl_q;
                            2'd1:    rdata_d = data_q;
                            2'd2:    rdata_d = status_q;
                            default: rdata_d = result_q;
                        endcase
`ifdef AXIL_STATUS_RDCLR_EN
                        status_clr_c = (addr_idx(s_axi_araddr) == 2'd2);
`endif
                    end else begin
                        rresp_d = RESP_SLVERR;
                        rdata_d = '0;
                    end
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rvalid_d = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        arready_d = !rvalid_d;
    end

    // Register bank; a read-clear of STATUS precedes a same-edge increment.
    always_comb begin
        ctrl_d   = ctrl_q;
        data_d   = data_q;
        status_d = status_q;
        result_d = ctrl_q + data_q;
        if (status_clr_c) status_d = '0;
        if (commit_c && commit_ok_c) begin
            status_d = status_d + DATA_WIDTH'(1);
            if (addr_idx(eff_addr) == 2'd0) ctrl_d = merge(ctrl_q, eff_data, eff_strb);
            else                            data_d = merge(data_q, eff_data, eff_strb);
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            ctrl_q    <= '0;
            data_q    <= '0;
            status_q  <= '0;
            result_q  <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ctrl_q    <= ctrl_d;
            data_q    <= data_d;
            status_q  <= status_d;
            result_q  <= result_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed vector table, corner sequences, random traffic vs model.
module tb_axil_reg_slave;
    localparam int unsigned BASE = 16;
    localparam logic [2:0] OKAY   = 3'd0;
    localparam logic [2:0] SLVERR = 3'd2;
`ifdef AXIL_STATUS_RDCLR_EN
    localparam logic [31:0] STATUS_REREAD = 32'd0;
`else
    localparam logic [31:0] STATUS_REREAD = 32'd3;
`endif

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [4:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [2:0]  bresp, rresp;
    logic [31:0] rdata;

    axil_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .BASE_ADDR(BASE)) dut (
        .s_axi_aclk(clk), .s_axi_areset(areset),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_ctrl = '0, m_data = '0, m_status = '0;

    typedef struct {
        bit          wr;
        logic [7:0]  off;
        logic [31:0] data;
        logic [4:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [2:0]  resp;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake timeout", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: register window semantics from the register map.
    task automatic model_reset();
        m_ctrl = '0; m_data = '0; m_status = '0;
    endtask

    task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                               output logic [2:0] resp);
        logic [7:0]  off;
        logic [31:0] mask;
        off = addr - 8'(BASE);
        if (off >= 8'd8 || addr[1:0] != 2'b00) begin
            resp = SLVERR;
        end else begin
            mask = '0;
            for (int i = 0; i < 4; i++) if (strb[i]) mask = mask | (32'hFF << (8 * i));
            if (off == 8'd0) m_ctrl = (m_ctrl & ~mask) | (data & mask);
            else             m_data = (m_data & ~mask) | (data & mask);
            m_status = m_status + 32'd1;
            resp = OKAY;
        end
    endtask

    task automatic model_read(input logic [7:0] addr, output logic [31:0] data, output logic [2:0] resp);
        logic [7:0] off;
        off = addr - 8'(BASE);
        if (off >= 8'd16 || addr[1:0] != 2'b00) begin
            data = '0; resp = SLVERR;
        end else begin
            resp = OKAY;
            if (off == 8'd0)      data = m_ctrl;
            else if (off == 8'd4) data = m_data;
            else if (off == 8'd8) begin
                data = m_status;
`ifdef AXIL_STATUS_RDCLR_EN
                m_status = '0;
`endif
            end else data = m_ctrl + m_data;
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        tick();
        check("reset_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}, 64'd0);
        areset = 1'b0;
        model_reset();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(awready && wready && arready) && n < 20) begin tick(); n++; end
        if (!(awready && wready && arready)) timeout_fail("wait_idle");
    endtask

    task automatic axi_write(input string name, input logic [7:0] addr, input logic [31:0] data,
                             input logic [4:0] strb, input int aw_dly, input int w_dly, input int b_dly,
                             input logic [2:0] exp_resp);
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        int cyc = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done)) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            aw_now  = awvalid && awready;
            w_now   = wvalid && wready;
            tick();
            aw_done = aw_done | aw_now;
            w_done  = w_done | w_now;
            cyc++;
            if (cyc > 60) begin
                timeout_fail({name, "_aw_w"});
                awvalid = 0; wvalid = 0;
                return;
            end
        end
        awvalid = 0; wvalid = 0;
        check({name, "_b"}, {bvalid, bresp}, {1'b1, exp_resp});
        for (int i = 0; i < b_dly; i++) begin
            tick();
            check({name, "_bhold"}, {bvalid, bresp, awready, wready}, {1'b1, exp_resp, 2'b00});
        end
        bready = 1; tick(); bready = 0;
        check({name, "_bdrop"}, bvalid, 1'b0);
    endtask

    task automatic axi_read(input string name, input logic [7:0] addr, input int r_dly,
                            input logic [31:0] exp_data, input logic [2:0] exp_resp);
        int n = 0;
        araddr = addr; arvalid = 1;
        while (!arready && n < 60) begin tick(); n++; end
        if (!arready) begin
            timeout_fail({name, "_ar"});
            arvalid = 0;
            return;
        end
        tick(); arvalid = 0;
        check({name, "_r"}, {rvalid, rresp, rdata}, {1'b1, exp_resp, exp_data});
        for (int i = 0; i < r_dly; i++) begin
            tick();
            check({name, "_rhold"}, {rvalid, rresp, rdata, arready}, {1'b1, exp_resp, exp_data, 1'b0});
        end
        rready = 1; tick(); rready = 0;
        check({name, "_rdrop"}, {rvalid, arready}, 2'b01);
    endtask

    task automatic mwrite(input string name, input logic [7:0] addr, input logic [31:0] data,
                          input logic [4:0] strb, input int aw_dly, input int w_dly, input int b_dly);
        logic [2:0] er;
        model_write(addr, data, strb, er);
        axi_write(name, addr, data, strb, aw_dly, w_dly, b_dly, er);
    endtask

    task automatic mread(input string name, input logic [7:0] addr, input int r_dly);
        logic [31:0] ed;
        logic [2:0]  er;
        model_read(addr, ed, er);
        axi_read(name, addr, r_dly, ed, er);
    endtask

    initial begin
        logic [7:0]  addr, off;
        logic [31:0] d, old_v;
        logic [2:0]  r;

        // wr, off, data, strb, aw_dly, w_dly, resp, rdata (register state starts from reset)
        vecs.push_back('{1, 8'h04, 32'hAABBCCDD, 5'h05, 0, 0, OKAY,   32'h0});
        vecs.push_back('{0, 8'h04, 32'h0,        5'h0,  0, 0, OKAY,   32'h00BB00DD});
        vecs.push_back('{0, 8'h00, 32'h0,        5'h0,  0, 0, OKAY,   32'h0});
        vecs.push_back('{0, 8'h0C, 32'h0,        5'h0,  0, 0, OKAY,   32'h00BB00DD});
        vecs.push_back('{1, 8'h00, 32'h11223344, 5'h0F, 0, 1, OKAY,   32'h0});
        vecs.push_back('{0, 8'h00, 32'h0,        5'h0,  0, 0, OKAY,   32'h11223344});
        vecs.push_back('{0, 8'h0C, 32'h0,        5'h0,  0, 0, OKAY,   32'h11DD3421});
        vecs.push_back('{1, 8'h08, 32'hFFFFFFFF, 5'h0F, 0, 0, SLVERR, 32'h0});
        vecs.push_back('{0, 8'h08, 32'h0,        5'h0,  0, 0, OKAY,   32'h2});
        vecs.push_back('{0, 8'h20, 32'h0,        5'h0,  0, 0, SLVERR, 32'h0});
        vecs.push_back('{0, 8'h02, 32'h0,        5'h0,  0, 0, SLVERR, 32'h0});
        vecs.push_back('{1, 8'h0C, 32'h12345678, 5'h0F, 0, 0, SLVERR, 32'h0});
        vecs.push_back('{1, 8'h14, 32'h12345678, 5'h0F, 1, 0, SLVERR, 32'h0});
        vecs.push_back('{1, 8'h01, 32'h12345678, 5'h0F, 0, 0, SLVERR, 32'h0});
        vecs.push_back('{1, 8'h00, 32'hDEADBEEF, 5'h00, 0, 0, OKAY,   32'h0});
        vecs.push_back('{0, 8'h00, 32'h0,        5'h0,  0, 0, OKAY,   32'h11223344});
        vecs.push_back('{1, 8'h04, 32'h55667788, 5'h1A, 0, 0, OKAY,   32'h0});
        vecs.push_back('{0, 8'h04, 32'h0,        5'h0,  0, 0, OKAY,   32'h55BB77DD});
        vecs.push_back('{0, 8'hF0, 32'h0,        5'h0,  0, 0, SLVERR, 32'h0});
        vecs.push_back('{1, 8'h00, 32'h01020304, 5'h0F, 2, 0, OKAY,   32'h0});
        vecs.push_back('{0, 8'h00, 32'h0,        5'h0,  0, 0, OKAY,   32'h01020304});
        vecs.push_back('{0, 8'h0C, 32'h0,        5'h0,  0, 0, OKAY,   32'h56BD7AE1});

        do_reset();

        foreach (vecs[i]) begin
            addr = 8'(BASE) + vecs[i].off;
            if (vecs[i].wr) begin
                model_write(addr, vecs[i].data, vecs[i].strb, r);
                axi_write($sformatf("vec%0d", i), addr, vecs[i].data, vecs[i].strb,
                          vecs[i].aw_dly, vecs[i].w_dly, 1, vecs[i].resp);
            end else begin
                model_read(addr, d, r);
                axi_read($sformatf("vec%0d", i), addr, 1, vecs[i].rdata, vecs[i].resp);
            end
        end

        // STATUS counts OKAY writes only; second read depends on read-clear.
        do_reset();
        mwrite("st_w0", 8'(BASE + 0), 32'h1, 5'h0F, 0, 0, 0);
        mwrite("st_w1", 8'(BASE + 4), 32'h2, 5'h00, 0, 0, 0);
        mwrite("st_err", 8'(BASE + 8), 32'h9, 5'h0F, 0, 0, 0);
        mwrite("st_w2", 8'(BASE + 0), 32'h3, 5'h10, 0, 0, 0);
        model_read(8'(BASE + 8), d, r);
        axi_read("status_1st", 8'(BASE + 8), 0, 32'd3, OKAY);
        model_read(8'(BASE + 8), d, r);
        axi_read("status_2nd", 8'(BASE + 8), 0, STATUS_REREAD, OKAY);

        // B stalled for 5 cycles with a second AW pending.
        wait_idle();
        awaddr = 8'(BASE + 0); wdata = 32'hA5; wstrb = 5'h0F; awvalid = 1; wvalid = 1;
        tick();
        wvalid = 0;
        model_write(8'(BASE + 0), 32'hA5, 5'h0F, r);
        awaddr = 8'(BASE + 4); wdata = 32'h5A;
        for (int i = 0; i < 5; i++) begin
            check("b_stall", {bvalid, bresp, awready, wready}, {1'b1, OKAY, 2'b00});
            tick();
        end
        bready = 1; tick(); bready = 0;
        check("b_release", {bvalid, awready}, 2'b01);
        tick();
        awvalid = 0;
        check("aw2_held", {awready, wready, bvalid}, 3'b010);
        wvalid = 1; tick(); wvalid = 0;
        model_write(8'(BASE + 4), 32'h5A, 5'h0F, r);
        check("aw2_commit", {bvalid, bresp}, {1'b1, OKAY});
        bready = 1; tick(); bready = 0;
        mread("aw2_rd_data", 8'(BASE + 4), 0);
        mread("aw2_rd_ctrl", 8'(BASE + 0), 0);

        // Read handshaking on the commit edge sees the pre-commit CTRL.
        wait_idle();
        old_v = m_ctrl;
        awaddr = 8'(BASE + 0); wdata = 32'hCAFEF00D; wstrb = 5'h0F; araddr = 8'(BASE + 0);
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("same_edge", {bvalid, bresp, rvalid, rresp, rdata}, {1'b1, OKAY, 1'b1, OKAY, old_v});
        model_write(8'(BASE + 0), 32'hCAFEF00D, 5'h0F, r);
        bready = 1; rready = 1; tick(); bready = 0; rready = 0;
        mread("same_edge_after", 8'(BASE + 0), 0);

        // RESULT read on the edge after a DATA commit returns the old sum.
        wait_idle();
        old_v = m_ctrl + m_data;
        d = m_data + 32'h100;
        awaddr = 8'(BASE + 4); wdata = d; wstrb = 5'h0F; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        model_write(8'(BASE + 4), d, 5'h0F, r);
        araddr = 8'(BASE + 12); arvalid = 1;
        tick();
        arvalid = 0;
        check("result_lag", {bvalid, rvalid, rresp, rdata}, {1'b1, 1'b1, OKAY, old_v});
        bready = 1; rready = 1; tick(); bready = 0; rready = 0;
        mread("result_new", 8'(BASE + 12), 0);

        // Reset while a response is pending aborts it.
        wait_idle();
        awaddr = 8'(BASE + 0); wdata = 32'h77; wstrb = 5'h0F; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        check("pre_reset_b", bvalid, 1'b1);
        do_reset();
        wait_idle();
        araddr = 8'(BASE + 4); arvalid = 1;
        tick();
        arvalid = 0;
        check("pre_reset_r", rvalid, 1'b1);
        do_reset();
        mwrite("post_reset_w", 8'(BASE + 4), 32'h1234, 5'h0F, 0, 0, 0);
        mread("post_reset_r", 8'(BASE + 4), 0);
        mread("post_reset_c", 8'(BASE + 0), 0);

        // Random traffic against the model.
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 7) < 5) off = 8'(4 * $urandom_range(0, 3));
            else                          off = 8'($urandom_range(0, 255));
            addr = 8'(BASE) + off;
            if ($urandom_range(0, 1) == 1)
                mwrite($sformatf("rnd%0d_w", t), addr, $urandom, 5'($urandom_range(0, 31)),
                       $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            else
                mread($sformatf("rnd%0d_r", t), addr, $urandom_range(0, 2));
        end
        mread("final_status", 8'(BASE + 8), 0);
        mread("final_result", 8'(BASE + 12), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
